// File: rtl/sram_256x8.sv
// rtl/sram_256x8.sv - single-port synchronous SRAM model with start/done handshake and shared data bus
module sram_256x8 #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [DATA_W-1:0] data,
    output logic              done,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    input  logic              start
);

    // A latency below one behaves as one; the counter only ever holds LAT_EFF-1 down to 0.
    localparam int LAT_EFF = (LATENCY < 1) ? 1 : LATENCY;
    localparam int CNT_W   = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_we;

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    // Next-state logic: capture the request in IDLE, count down in BUSY, hold DONE until start drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                    addr_d  = addr;
                    wr_d    = write;
                    if (write) begin
                        wdata_d = data;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                // A start still held here is the tail of this request, never a new one.
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and captured-request registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array write port; mem_we is only raised from BUSY, so a reset mid-operation never commits.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign done = (state_q == S_DONE);

    // The memory drives the bus only while presenting read data; writes leave it to the master.
    assign data = (state_q == S_DONE && !wr_q) ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_256x8.sv
// tb/tb_sram_256x8.sv - self-checking bench for sram_256x8
module tb_sram_256x8;

    localparam int LAT     = 2;
    localparam int TIMEOUT = 20;
    localparam logic [7:0] BUS_IDLE = 8'hFF;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr;
    logic       write;
    logic       start;
    logic       done;
    logic [7:0] tb_drv;
    logic       tb_oe;
    wire  [7:0] data;

    // Pull-ups make a released bus read as all ones.
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data[i]);
    end

    assign data = tb_oe ? tb_drv : 8'hzz;

    sram_256x8 #(.ADDR_W(8), .DATA_W(8), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .done  (done),
        .addr  (addr),
        .write (write),
        .start (start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        int         hold;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " latency"}, n, LAT);
    endtask

    task automatic check_read(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({name, " scoreboard empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({name, " rdata"}, int'(data), int'(e));
        end
    endtask

    task automatic do_op(input vec_t v, input string name);
        @(negedge clk);
        start = 1'b1;
        write = v.wr;
        addr  = v.addr;
        if (v.wr) begin
            tb_drv = v.wdata;
            tb_oe  = 1'b1;
        end else begin
            exp_q.push_back(v.exp);
        end
        @(posedge clk);
        #1;
        // Request is captured; scramble inputs and release the bus to show they are ignored.
        tb_oe  = 1'b0;
        addr   = ~v.addr;
        write  = ~v.wr;
        tb_drv = ~v.wdata;
        wait_done(name);
        if (v.wr) check({name, " bus released on write"}, int'(data), int'(BUS_IDLE));
        else      check_read(name);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            #1;
            check({name, " done held"}, int'(done), 1);
            if (!v.wr) check({name, " data held"}, int'(data), int'(v.exp));
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({name, " done cleared"}, int'(done), 0);
        check({name, " bus released"}, int'(data), int'(BUS_IDLE));
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{wr: 1'b1, addr: 8'h03, wdata: 8'hA5, exp: 8'h00, hold: 0};
        vecs[1]  = '{wr: 1'b0, addr: 8'h03, wdata: 8'h00, exp: 8'hA5, hold: 5};
        vecs[2]  = '{wr: 1'b1, addr: 8'h00, wdata: 8'h11, exp: 8'h00, hold: 0};
        vecs[3]  = '{wr: 1'b1, addr: 8'hFF, wdata: 8'hEE, exp: 8'h00, hold: 0};
        vecs[4]  = '{wr: 1'b0, addr: 8'h00, wdata: 8'h00, exp: 8'h11, hold: 0};
        vecs[5]  = '{wr: 1'b0, addr: 8'hFF, wdata: 8'h00, exp: 8'hEE, hold: 1};
        vecs[6]  = '{wr: 1'b1, addr: 8'h10, wdata: 8'h3C, exp: 8'h00, hold: 0};
        vecs[7]  = '{wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp: 8'h3C, hold: 0};
        vecs[8]  = '{wr: 1'b1, addr: 8'h04, wdata: 8'h5A, exp: 8'h00, hold: 2};
        vecs[9]  = '{wr: 1'b0, addr: 8'h04, wdata: 8'h00, exp: 8'h5A, hold: 0};
        vecs[10] = '{wr: 1'b0, addr: 8'h03, wdata: 8'h00, exp: 8'hA5, hold: 0};

        rst_n  = 1'b0;
        start  = 1'b0;
        write  = 1'b0;
        addr   = 8'h00;
        tb_drv = 8'h00;
        tb_oe  = 1'b0;
        #1;
        check("reset done", int'(done), 0);
        check("reset bus", int'(data), int'(BUS_IDLE));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset while read data is on the bus.
        @(negedge clk);
        start = 1'b1;
        write = 1'b0;
        addr  = 8'h03;
        exp_q.push_back(8'hA5);
        @(posedge clk);
        #1;
        wait_done("async rst read");
        check_read("async rst read");
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst done", int'(done), 0);
        check("async rst bus", int'(data), int'(BUS_IDLE));
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset one cycle into a write of 0x55 to 0x10 must leave 0x3C in place.
        @(negedge clk);
        start  = 1'b1;
        write  = 1'b1;
        addr   = 8'h10;
        tb_drv = 8'h55;
        tb_oe  = 1'b1;
        @(posedge clk);
        #1;
        tb_oe = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort done", int'(done), 0);
        check("abort bus", int'(data), int'(BUS_IDLE));
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op('{wr: 1'b0, addr: 8'h10, wdata: 8'h00, exp: 8'h3C, hold: 0}, "abort readback");

        // Start pulsed for a single cycle: operation completes and done lasts one cycle.
        @(negedge clk);
        start = 1'b1;
        write = 1'b0;
        addr  = 8'h03;
        exp_q.push_back(8'hA5);
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        addr  = 8'h77;
        wait_done("early release");
        check_read("early release");
        @(posedge clk);
        #1;
        check("early release done pulse", int'(done), 0);
        check("early release bus", int'(data), int'(BUS_IDLE));

        check("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
